// File: rtl/tetris.sv
// rtl/tetris.sv - shared opcode set for the plate and its opcode sources
package tetris;

  typedef enum logic [2:0] {
    eNop       = 3'd0,
    eNew       = 3'd1,
    eMoveDown  = 3'd2,
    eMoveLeft  = 3'd3,
    eMoveRight = 3'd4,
    eRotate    = 3'd5,
    eCommit    = 3'd6,
    eCheck     = 3'd7
  } opcode_e;

endpackage

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - turns buttons and gravity into plate opcodes, runs the landing chain, keeps score
module game_sequencer
  import tetris::*;
#(
  parameter int gravity_period_p = 25_000_000,
  parameter int score_width_p    = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     left_i,
  input  logic                     right_i,
  input  logic                     rotate_i,
  input  logic                     drop_i,
  output opcode_e                  opcode_o,
  output logic                     opcode_v_o,
  input  logic                     ready_i,
  input  logic                     done_i,
  output logic                     yumi_o,
  input  logic                     block_cannot_move_down_i,
  input  logic                     lose_i,
  input  logic [2:0]               line_elimination_i,
  input  logic                     line_elimination_v_i,
  output logic                     playing_o,
  output logic                     game_over_o,
  output logic [score_width_p-1:0] score_o,
  output logic [score_width_p-1:0] lines_o
);

  localparam int cnt_w = (gravity_period_p > 2) ? $clog2(gravity_period_p) : 1;

  typedef enum logic [2:0] {eIdle, eDecide, eIssue, eWait, eOver} state_e;

  state_e                   r_state;
  opcode_e                  r_opcode;
  logic                     r_opcode_v;
  logic                     r_left, r_right, r_rot, r_drop, r_tick;
  logic [cnt_w-1:0]         r_cnt;
  logic [score_width_p-1:0] r_score, r_lines;

  logic                     w_running, w_wrap, w_start;
  logic                     w_sel;
  opcode_e                  w_sel_op;
  logic                     w_clr_left, w_clr_right, w_clr_rot, w_clr_drop, w_clr_tick;
  logic [2:0]               w_lines_n;
  logic [3:0]               w_pts;
  logic [score_width_p:0]   w_line_sum, w_score_sum;

  assign w_running = (r_state == eDecide) || (r_state == eIssue) || (r_state == eWait);
  assign w_wrap    = w_running && (r_cnt == cnt_w'(gravity_period_p - 1));
  assign w_start   = (r_state == eIdle) && start_i;

  // One source per eDecide cycle; drop outranks gravity so a hard drop is never interleaved.
  always_comb begin
    w_sel       = 1'b0;
    w_sel_op    = eNop;
    w_clr_left  = 1'b0;
    w_clr_right = 1'b0;
    w_clr_rot   = 1'b0;
    w_clr_drop  = 1'b0;
    w_clr_tick  = 1'b0;
    if (r_state == eDecide) begin
      if (r_drop) begin
        w_sel      = 1'b1;
        w_sel_op   = block_cannot_move_down_i ? eCommit : eMoveDown;
        w_clr_drop = block_cannot_move_down_i;
      end else if (r_tick) begin
        w_sel      = 1'b1;
        w_sel_op   = block_cannot_move_down_i ? eCommit : eMoveDown;
        w_clr_tick = 1'b1;
      end else if (r_rot) begin
        w_sel     = 1'b1;
        w_sel_op  = eRotate;
        w_clr_rot = 1'b1;
      end else if (r_left) begin
        w_sel      = 1'b1;
        w_sel_op   = eMoveLeft;
        w_clr_left = 1'b1;
      end else if (r_right) begin
        w_sel       = 1'b1;
        w_sel_op    = eMoveRight;
        w_clr_right = 1'b1;
      end
    end
  end

  assign w_lines_n = (line_elimination_i <= 3'd4) ? line_elimination_i : 3'd0;

  always_comb begin
    w_pts = 4'd0;
    case (line_elimination_i)
      3'd1:    w_pts = 4'd1;
      3'd2:    w_pts = 4'd3;
      3'd3:    w_pts = 4'd5;
      3'd4:    w_pts = 4'd8;
      default: w_pts = 4'd0;
    endcase
  end

  assign w_line_sum  = {1'b0, r_lines} + (score_width_p + 1)'(w_lines_n);
  assign w_score_sum = {1'b0, r_score} + (score_width_p + 1)'(w_pts);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= eIdle;
      r_opcode   <= eNop;
      r_opcode_v <= 1'b0;
      r_left     <= 1'b0;
      r_right    <= 1'b0;
      r_rot      <= 1'b0;
      r_drop     <= 1'b0;
      r_tick     <= 1'b0;
      r_cnt      <= '0;
      r_score    <= '0;
      r_lines    <= '0;
    end else begin
      // A pulse landing on the cycle its bit is consumed re-arms it.
      r_left  <= (r_left  & ~w_clr_left)  | (left_i   & w_running);
      r_right <= (r_right & ~w_clr_right) | (right_i  & w_running);
      r_rot   <= (r_rot   & ~w_clr_rot)   | (rotate_i & w_running);
      r_drop  <= (r_drop  & ~w_clr_drop)  | (drop_i   & w_running);
      r_tick  <= (r_tick  & ~w_clr_tick)  | w_wrap;
      if (w_running) r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;

      if (w_start) begin
        r_score <= '0;
        r_lines <= '0;
      end else if (line_elimination_v_i) begin
        r_lines <= w_line_sum[score_width_p]  ? '1 : w_line_sum[score_width_p-1:0];
        r_score <= w_score_sum[score_width_p] ? '1 : w_score_sum[score_width_p-1:0];
      end

      case (r_state)
        eIdle: begin
          if (start_i) begin
            r_opcode   <= eNew;
            r_opcode_v <= 1'b1;
            r_cnt      <= '0;
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_rot      <= 1'b0;
            r_drop     <= 1'b0;
            r_tick     <= 1'b0;
            r_state    <= eIssue;
          end
        end
        eDecide: begin
          if (w_sel) begin
            r_opcode   <= w_sel_op;
            r_opcode_v <= 1'b1;
            r_state    <= eIssue;
          end
        end
        eIssue: begin
          if (ready_i) begin
            r_opcode_v <= 1'b0;
            r_state    <= eWait;
          end
        end
        eWait: begin
          if (lose_i) begin
            r_opcode <= eNop;
            r_state  <= eOver;
          end else if (done_i) begin
            case (r_opcode)
              eCommit: begin
                r_opcode   <= eCheck;
                r_opcode_v <= 1'b1;
                r_state    <= eIssue;
              end
              eCheck: begin
                r_opcode   <= eNew;
                r_opcode_v <= 1'b1;
                r_state    <= eIssue;
              end
              default: r_state <= eDecide;
            endcase
          end
        end
        eOver:   r_state <= eOver;
        default: r_state <= eIdle;
      endcase
    end
  end

  assign opcode_o    = r_opcode;
  assign opcode_v_o  = r_opcode_v;
  assign yumi_o      = (r_state == eWait) && done_i;
  assign playing_o   = w_running;
  assign game_over_o = (r_state == eOver);
  assign score_o     = r_score;
  assign lines_o     = r_lines;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed vector bench for game_sequencer with an 8-cycle gravity period
module tb_game_sequencer;
  import tetris::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0, left_i = 1'b0, right_i = 1'b0, rotate_i = 1'b0, drop_i = 1'b0;
  logic        ready_i = 1'b0, done_i = 1'b0, cmd_i = 1'b0, lose_i = 1'b0;
  logic [2:0]  le_i = 3'd0;
  logic        le_v_i = 1'b0;
  opcode_e     opcode_o;
  logic        opcode_v_o, yumi_o, playing_o, game_over_o;
  logic [15:0] score_o, lines_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  game_sequencer #(.gravity_period_p(8), .score_width_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .left_i(left_i), .right_i(right_i), .rotate_i(rotate_i), .drop_i(drop_i),
    .opcode_o(opcode_o), .opcode_v_o(opcode_v_o), .ready_i(ready_i), .done_i(done_i),
    .yumi_o(yumi_o), .block_cannot_move_down_i(cmd_i), .lose_i(lose_i),
    .line_elimination_i(le_i), .line_elimination_v_i(le_v_i),
    .playing_o(playing_o), .game_over_o(game_over_o), .score_o(score_o), .lines_o(lines_o)
  );

  localparam logic [9:0] S = 10'h200, L = 10'h100, R = 10'h080, RO = 10'h040, D = 10'h020;
  localparam logic [9:0] RDY = 10'h010, DN = 10'h008, CMD = 10'h004, LS = 10'h002, LV = 10'h001;

  typedef struct {
    logic [9:0]  in;
    logic [2:0]  le;
    opcode_e     op;
    logic        v, y, p;
    logic [15:0] sc, ln;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [9:0] in, input logic [2:0] le, input opcode_e op,
                     input logic v, input logic y, input logic p,
                     input logic [15:0] sc, input logic [15:0] ln);
    vec_t r;
    r.in = in; r.le = le; r.op = op; r.v = v; r.y = y; r.p = p; r.sc = sc; r.ln = ln;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start_i = 0; left_i = 0; right_i = 0; rotate_i = 0; drop_i = 0;
    ready_i = 0; done_i = 0; lose_i = 0; le_v_i = 0; le_i = 3'd0;
  endtask

  // Plays the plate: waits for valid, accepts it, then returns done one cycle later.
  task automatic serve(input opcode_e exp, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); idle_inputs(); #1; n++;
    end while (!opcode_v_o && n < 40);
    if (!opcode_v_o) begin
      chk({name, "_timeout"}, 64'(opcode_v_o), 64'd1);
    end else begin
      chk(name, 64'(opcode_o), 64'(exp));
      ready_i = 1;
      @(negedge clk); idle_inputs(); done_i = 1; #1;
      chk({name, "_yumi"}, 64'(yumi_o), 64'd1);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_op"}, 64'(opcode_o), 64'(eNop));
    chk({name, "_flags"}, {60'd0, opcode_v_o, yumi_o, playing_o, game_over_o}, 64'd0);
    chk({name, "_totals"}, {32'd0, score_o, lines_o}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    add(S,      0, eNop,       0, 0, 0, 0, 0);
    add(0,      0, eNew,       1, 0, 1, 0, 0);
    add(0,      0, eNew,       1, 0, 1, 0, 0);
    add(RDY,    0, eNew,       1, 0, 1, 0, 0);
    add(0,      0, eNew,       0, 0, 1, 0, 0);
    add(DN,     0, eNew,       0, 1, 1, 0, 0);
    add(LV,     4, eNew,       0, 0, 1, 0, 0);
    add(LV,     1, eNew,       0, 0, 1, 8, 4);
    add(LV,     6, eNew,       0, 0, 1, 9, 5);
    add(0,      0, eNew,       0, 0, 1, 9, 5);
    add(RDY,    0, eMoveDown,  1, 0, 1, 9, 5);
    add(DN,     0, eMoveDown,  0, 1, 1, 9, 5);
    for (int i = 0; i < 6; i++) add(0, 0, eMoveDown, 0, 0, 1, 9, 5);
    add(RDY,    0, eMoveDown,  1, 0, 1, 9, 5);
    add(L | RO, 0, eMoveDown,  0, 0, 1, 9, 5);
    add(DN,     0, eMoveDown,  0, 1, 1, 9, 5);
    add(0,      0, eMoveDown,  0, 0, 1, 9, 5);
    add(RDY | L,0, eRotate,    1, 0, 1, 9, 5);
    add(DN,     0, eRotate,    0, 1, 1, 9, 5);
    add(0,      0, eRotate,    0, 0, 1, 9, 5);
    add(RDY,    0, eMoveLeft,  1, 0, 1, 9, 5);
    add(DN,     0, eMoveLeft,  0, 1, 1, 9, 5);
    add(0,      0, eMoveLeft,  0, 0, 1, 9, 5);
    add(RDY,    0, eMoveDown,  1, 0, 1, 9, 5);
    add(DN,     0, eMoveDown,  0, 1, 1, 9, 5);
    add(0,      0, eMoveDown,  0, 0, 1, 9, 5);
    add(0,      0, eMoveDown,  0, 0, 1, 9, 5);
    add(R,      0, eMoveDown,  0, 0, 1, 9, 5);
    add(0,      0, eMoveDown,  0, 0, 1, 9, 5);
    add(RDY,    0, eMoveDown,  1, 0, 1, 9, 5);
    add(DN,     0, eMoveDown,  0, 1, 1, 9, 5);
    add(0,      0, eMoveDown,  0, 0, 1, 9, 5);
    add(RDY,    0, eMoveRight, 1, 0, 1, 9, 5);
    add(DN,     0, eMoveRight, 0, 1, 1, 9, 5);
    add(0,      0, eMoveRight, 0, 0, 1, 9, 5);
    add(0,      0, eMoveRight, 0, 0, 1, 9, 5);
    add(CMD,    0, eMoveRight, 0, 0, 1, 9, 5);
    add(RDY,    0, eCommit,    1, 0, 1, 9, 5);
    add(DN,     0, eCommit,    0, 1, 1, 9, 5);
    add(RDY,    0, eCheck,     1, 0, 1, 9, 5);
    add(DN,     0, eCheck,     0, 1, 1, 9, 5);
    add(RDY,    0, eNew,       1, 0, 1, 9, 5);
    add(DN,     0, eNew,       0, 1, 1, 9, 5);
    add(0,      0, eNew,       0, 0, 1, 9, 5);

    @(negedge clk);
    @(negedge clk); #1;
    chk_reset_outputs("reset");
    reset_i = 0;

    foreach (tbl[i]) begin
      @(negedge clk);
      {start_i, left_i, right_i, rotate_i, drop_i, ready_i, done_i, cmd_i, lose_i, le_v_i} = tbl[i].in;
      le_i = tbl[i].le;
      #1;
      chk($sformatf("row%0d_op", i), 64'(opcode_o), 64'(tbl[i].op));
      chk($sformatf("row%0d_flags", i), {60'd0, opcode_v_o, yumi_o, playing_o, game_over_o},
          {60'd0, tbl[i].v, tbl[i].y, tbl[i].p, 1'b0});
      chk($sformatf("row%0d_totals", i), {32'd0, score_o, lines_o}, {32'd0, tbl[i].sc, tbl[i].ln});
    end
    cmd_i = 0;

    // Hard drop: pending gravity tick first, then the drop walks three rows and lands.
    serve(eMoveDown, "tick_before_drop");
    @(negedge clk); idle_inputs(); drop_i = 1; #1;
    serve(eMoveDown, "drop1");
    serve(eMoveDown, "drop2");
    serve(eMoveDown, "drop3");
    cmd_i = 1;
    serve(eCommit, "drop_commit");
    serve(eCheck, "drop_check");
    serve(eNew, "drop_new");
    cmd_i = 0;

    // Saturation: both totals would wrap without clamping.
    for (int i = 0; i < 16400; i++) begin
      @(negedge clk); idle_inputs(); le_v_i = 1; le_i = 3'd4;
    end
    @(negedge clk); idle_inputs(); le_v_i = 1; le_i = 3'd3; #1;
    chk("sat_score", 64'(score_o), 64'd65535);
    chk("sat_lines", 64'(lines_o), 64'd65535);
    @(negedge clk); idle_inputs(); #1;
    chk("sat_hold", {32'd0, score_o, lines_o}, {32'd0, 16'hffff, 16'hffff});

    // Loss while waiting for done.
    @(negedge clk); idle_inputs(); ready_i = 1; #1;
    chk("loss_issue_v", 64'(opcode_v_o), 64'd1);
    @(negedge clk); idle_inputs(); lose_i = 1; #1;
    chk("loss_wait_yumi", 64'(yumi_o), 64'd0);
    chk("loss_wait_over", 64'(game_over_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_inputs();
      lose_i = 1; left_i = 1; rotate_i = 1; drop_i = 1; start_i = 1; ready_i = 1; done_i = 1;
      #1;
      chk($sformatf("over%0d_flags", i), {60'd0, opcode_v_o, yumi_o, playing_o, game_over_o}, 64'd1);
    end

    @(negedge clk); idle_inputs(); lose_i = 1; reset_i = 1; #1;
    @(negedge clk); idle_inputs(); reset_i = 0; #1;
    chk_reset_outputs("after_loss_reset");

    // Reset during an outstanding eIssue.
    @(negedge clk); idle_inputs(); start_i = 1; #1;
    @(negedge clk); idle_inputs(); #1;
    chk("restart_op", 64'(opcode_o), 64'(eNew));
    chk("restart_v", 64'(opcode_v_o), 64'd1);
    @(negedge clk); idle_inputs(); reset_i = 1; #1;
    @(negedge clk); idle_inputs(); reset_i = 0; #1;
    chk_reset_outputs("mid_issue_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Opcode source for `game_plate`. It drives the plate's opcode/valid/ready/done/yumi handshake, turning player buttons and a gravity timer into opcodes from the `tetris` package `opcode_e` set. It runs the commit → check → new chain when a tile lands, and accumulates line and score totals. It sits between the input debouncers and `game_plate`, one instance per game.

## Interface
- gravity_period_p, 25_000_000, clock cycles per gravity tick (≥2)
- score_width_p, 16, width of score_o and lines_o

- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  pulse; starts a game from eIdle
- left_i / right_i / rotate_i / drop_i  in  1 each  one-cycle button pulses
- opcode_o  out  opcode_e  opcode to plate
- opcode_v_o  out  1  opcode valid
- ready_i  in  1  plate ready (plate ready_o)
- done_i  in  1  plate done (plate done_o)
- yumi_o  out  1  acknowledge of done_i
- block_cannot_move_down_i  in  1  plate block_cannot_move_down_o
- lose_i  in  1  plate lose_o
- line_elimination_i  in  3  lines cleared by last check
- line_elimination_v_i  in  1  line_elimination_i valid
- playing_o  out  1  game in progress
- game_over_o  out  1  sticky loss flag
- score_o  out  score_width_p  saturating score
- lines_o  out  score_width_p  saturating cleared-line count

## Operation
- States: eIdle, eDecide, eIssue, eWait, eOver.
- eIdle: start_i loads opcode_r=eNew, clears the gravity counter and all pending bits, then goes to eIssue.
- eIssue: opcode_o=opcode_r and opcode_v_o=1. On opcode_v_o && ready_i go to eWait.
- eWait: yumi_o=done_i, combinational. On done_i the next state follows opcode_r:
  - eCommit → opcode_r=eCheck, eIssue
  - eCheck → opcode_r=eNew, eIssue
  - else → eDecide
- eWait with lose_i=1 → eOver, regardless of done_i. The plate never raises done once lost.
- eDecide picks the highest priority source in a single cycle:
  1. drop_r: cannot_move_down → eCommit and clear drop_r; else eMoveDown.
  2. tick_r: clear it; cannot_move_down → eCommit; else eMoveDown.
  3. rot_r → eRotate; clear rot_r.
  4. left_r → eMoveLeft; clear left_r.
  5. right_r → eMoveRight; clear right_r.
  - With a source selected, go to eIssue. With none, stay in eDecide with opcode_v_o=0.
- Pending bits: left_r, right_r, rot_r and drop_r are set by their pulses in eDecide, eIssue and eWait. Each holds one event; repeats before consumption merge. Pulses are ignored in eIdle and eOver.
- Gravity: the counter runs in eDecide, eIssue and eWait. At gravity_period_p−1 it wraps to 0 and sets tick_r. A tick while tick_r is set is lost.
- Scoring on line_elimination_v_i, adding n = line_elimination_i:
  - lines_o += n
  - score_o += 0/1/3/5/8 for n = 0/1/2/3/4
  - n ≥ 5 adds 0 to both
  - Both totals saturate at all-ones and clear on start_i.
- eOver: game_over_o=1, all handshake outputs low. Only reset_i leaves eOver, because the plate's loss flag clears only on reset.
- playing_o=1 in eDecide, eIssue and eWait.

## Timing
- Reset values:
  - Outputs: state eIdle, opcode_o=eNop, opcode_v_o=0, yumi_o=0, playing_o=0, game_over_o=0, score_o=0, lines_o=0.
  - Internal: counter=0, all pending bits 0.
- Button latency, from a pulse at cycle t with the sequencer idle in eDecide:
  - pending bit set at t+1
  - eIssue with opcode_v_o=1 at t+2
- opcode_o and opcode_v_o are registered and stable until accepted. Valid is never dropped without ready_i.
- yumi_o is high exactly in cycles where state==eWait && done_i, and for one cycle per opcode.
- A pulse in the same cycle its own bit is cleared leaves the bit set; set wins.
- A tick and a button in the same eDecide cycle: the tick is served and the button stays pending.
- reset_i has priority in every state, including a mid-handshake eIssue or eWait.

## Test plan
- **Start:** gravity_period_p=8; reset, start_i → opcode_o=eNew, opcode_v_o=1 until ready_i; yumi_o for one cycle on done_i.
- **Gravity:** idle in eDecide, block_cannot_move_down_i=0 → eMoveDown issued every 8 cycles. With cannot_move_down=1 → eCommit, eCheck, eNew back-to-back.
- **Buttons:** pulse left_i and rotate_i in the same cycle while in eWait → after done, eRotate then eMoveLeft. A second left_i before consumption yields a single eMoveLeft.
- **Hard drop:** drop_i, and cannot_move_down rises after three moves → exactly three eMoveDown, then eCommit, eCheck, eNew.
- **Score:** line_elimination_v_i with n=4, then n=1, then n=6 → lines_o=5, score_o=9. Preload near max → saturates at 65535.
- **Loss and reset:** lose_i=1 in eWait with done_i=0 → eOver, game_over_o=1, opcode_v_o=0, buttons ignored. reset_i → all outputs at reset values in the next cycle.
